// File: rtl/alu_pkg.sv
// Shared encodings for the nibble-serial ALU: op codes, sequencer states,
// per-op core control table and op classification helpers.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0, OP_ADC = 3'd1, OP_SUB = 3'd2, OP_SBC = 3'd3,
    OP_AND = 3'd4, OP_XOR = 3'd5, OP_OR  = 3'd6, OP_CP  = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE, S_LOAD_A, S_LOW, S_HIGH
  } seq_state_t;

  // {R,S,V} core select; all arithmetic ops run the plain adder (000).
  localparam logic [2:0] ALU_RSV [0:7] = '{
    3'b000, 3'b000, 3'b000, 3'b000,
    3'b100, 3'b010, 3'b001, 3'b000
  };

  function automatic logic op_is_sub(alu_op_t o);
    return (o == OP_SUB) || (o == OP_SBC) || (o == OP_CP);
  endfunction

  function automatic logic op_is_logic(alu_op_t o);
    return (o == OP_AND) || (o == OP_XOR) || (o == OP_OR);
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Three-cycle controller for the nibble-serial ALU: load A, low nibble with
// operand B, high nibble with result, then flag capture.
module alu_sequencer
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       nreset,
  input  logic       start,
  input  logic [2:0] op,
  output logic       busy,
  output logic       done,
  output logic       opa_req,
  output logic       opb_req,
  output logic       alu_oe,
  output logic       alu_shift_oe,
  output logic       alu_op1_oe,
  output logic       alu_op2_oe,
  output logic       alu_res_oe,
  output logic       alu_bs_oe,
  output logic       alu_op1_sel_bus,
  output logic       alu_op2_sel_bus,
  output logic       alu_sel_op2_neg,
  output logic       alu_sel_op2_high,
  output logic       alu_op_low,
  output logic       alu_core_cf_in,
  output logic       alu_core_R,
  output logic       alu_core_S,
  output logic       alu_core_V,
  output logic       alu_parity_in,
  input  logic       alu_core_cf_out,
  input  logic       alu_parity_out,
  input  logic       alu_zero,
  input  logic       alu_sf_out,
  output logic       cf,
  output logic       hf,
  output logic       pf,
  output logic       zf,
  output logic       sf
);

  seq_state_t state;
  alu_op_t    op_q;
  logic       cin_q, t_hc, t_zlo;

  // Operand latches are never read back onto the internal bus by this sequence.
  assign alu_op1_oe = 1'b0;
  assign alu_op2_oe = 1'b0;
  assign alu_bs_oe  = 1'b0;

  // Outputs are registered for the state being entered; low-nibble parity
  // is held directly in alu_parity_in for the high phase.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state            <= S_IDLE;
      op_q             <= OP_ADD;
      cin_q            <= 1'b0;
      t_hc             <= 1'b0;
      t_zlo            <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      opa_req          <= 1'b0;
      opb_req          <= 1'b0;
      alu_oe           <= 1'b0;
      alu_shift_oe     <= 1'b0;
      alu_res_oe       <= 1'b0;
      alu_op1_sel_bus  <= 1'b0;
      alu_op2_sel_bus  <= 1'b0;
      alu_sel_op2_neg  <= 1'b0;
      alu_sel_op2_high <= 1'b0;
      alu_op_low       <= 1'b0;
      alu_core_cf_in   <= 1'b0;
      {alu_core_R, alu_core_S, alu_core_V} <= 3'b000;
      alu_parity_in    <= 1'b0;
    end else begin
      busy             <= 1'b0;
      done             <= 1'b0;
      opa_req          <= 1'b0;
      opb_req          <= 1'b0;
      alu_oe           <= 1'b0;
      alu_shift_oe     <= 1'b0;
      alu_res_oe       <= 1'b0;
      alu_op1_sel_bus  <= 1'b0;
      alu_op2_sel_bus  <= 1'b0;
      alu_sel_op2_neg  <= 1'b0;
      alu_sel_op2_high <= 1'b0;
      alu_op_low       <= 1'b0;
      alu_core_cf_in   <= 1'b0;
      {alu_core_R, alu_core_S, alu_core_V} <= 3'b000;
      alu_parity_in    <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state           <= S_LOAD_A;
          op_q            <= alu_op_t'(op);
          cin_q           <= ((op == OP_ADC) || (op == OP_SBC)) && cf;
          busy            <= 1'b1;
          opa_req         <= 1'b1;
          alu_shift_oe    <= 1'b1;
          alu_op1_sel_bus <= 1'b1;
        end
        S_LOAD_A: begin
          state           <= S_LOW;
          busy            <= 1'b1;
          opb_req         <= 1'b1;
          alu_shift_oe    <= 1'b1;
          alu_op2_sel_bus <= 1'b1;
          alu_op_low      <= 1'b1;
          alu_sel_op2_neg <= op_is_sub(op_q);
          alu_core_cf_in  <= cin_q ^ op_is_sub(op_q);
          {alu_core_R, alu_core_S, alu_core_V} <= ALU_RSV[op_q];
        end
        S_LOW: begin
          state            <= S_HIGH;
          t_hc             <= alu_core_cf_out;
          t_zlo            <= alu_zero;
          busy             <= 1'b1;
          done             <= 1'b1;
          alu_res_oe       <= 1'b1;
          alu_oe           <= (op_q != OP_CP);
          alu_sel_op2_high <= 1'b1;
          alu_sel_op2_neg  <= op_is_sub(op_q);
          alu_core_cf_in   <= alu_core_cf_out;
          alu_parity_in    <= alu_parity_out;
          {alu_core_R, alu_core_S, alu_core_V} <= ALU_RSV[op_q];
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      {cf, hf, pf, zf, sf} <= 5'b0;
    end else if (state == S_HIGH) begin
      if (op_is_logic(op_q)) begin
        cf <= 1'b0;
        hf <= (op_q == OP_AND);
      end else begin
        cf <= alu_core_cf_out ^ op_is_sub(op_q);
        hf <= t_hc ^ op_is_sub(op_q);
      end
      pf <= alu_parity_out;
      zf <= t_zlo & alu_zero;
      sf <= alu_sf_out;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized bench: a nibble ALU emulator closes the loop around the
// sequencer, and flags/results are compared with 8-bit arithmetic.
module tb_alu_sequencer;

  logic clk = 1'b0, nreset = 1'b0, start = 1'b0;
  logic [2:0] op = 3'd0;
  logic busy, done, opa_req, opb_req, alu_oe, alu_shift_oe, alu_op1_oe, alu_op2_oe;
  logic alu_res_oe, alu_bs_oe, alu_op1_sel_bus, alu_op2_sel_bus, alu_sel_op2_neg;
  logic alu_sel_op2_high, alu_op_low, alu_core_cf_in, alu_core_R, alu_core_S, alu_core_V;
  logic alu_parity_in, alu_core_cf_out, alu_parity_out, alu_zero, alu_sf_out;
  logic cf, hf, pf, zf, sf;

  int n_chk = 0, n_fail = 0;
  logic model_cf = 1'b0;

  alu_sequencer dut (
    .clk(clk), .nreset(nreset), .start(start), .op(op), .busy(busy), .done(done),
    .opa_req(opa_req), .opb_req(opb_req), .alu_oe(alu_oe), .alu_shift_oe(alu_shift_oe),
    .alu_op1_oe(alu_op1_oe), .alu_op2_oe(alu_op2_oe), .alu_res_oe(alu_res_oe),
    .alu_bs_oe(alu_bs_oe), .alu_op1_sel_bus(alu_op1_sel_bus),
    .alu_op2_sel_bus(alu_op2_sel_bus), .alu_sel_op2_neg(alu_sel_op2_neg),
    .alu_sel_op2_high(alu_sel_op2_high), .alu_op_low(alu_op_low),
    .alu_core_cf_in(alu_core_cf_in), .alu_core_R(alu_core_R), .alu_core_S(alu_core_S),
    .alu_core_V(alu_core_V), .alu_parity_in(alu_parity_in),
    .alu_core_cf_out(alu_core_cf_out), .alu_parity_out(alu_parity_out),
    .alu_zero(alu_zero), .alu_sf_out(alu_sf_out),
    .cf(cf), .hf(hf), .pf(pf), .zf(zf), .sf(sf)
  );

  always #5 clk = ~clk;

  logic [24:0] all_outs;
  assign all_outs = {busy, done, opa_req, opb_req, alu_oe, alu_shift_oe, alu_op1_oe,
                     alu_op2_oe, alu_res_oe, alu_bs_oe, alu_op1_sel_bus, alu_op2_sel_bus,
                     alu_sel_op2_neg, alu_sel_op2_high, alu_op_low, alu_core_cf_in,
                     alu_core_R, alu_core_S, alu_core_V, alu_parity_in, cf, hf, pf, zf, sf};

  // ALU emulator: transparent operand latches, one nibble per cycle.
  logic [7:0] opa = 8'h00, opb = 8'h00, db, op1_q, op2_q, op1, op2, b2;
  logic [3:0] na, nb, nib, lo_q;
  logic [4:0] s5;
  logic       co;
  assign db = opa_req ? opa : (opb_req ? opb : 8'h00);

  always @(posedge clk) begin
    if (alu_op1_sel_bus) op1_q <= db;
    if (alu_op2_sel_bus) op2_q <= db;
    if (alu_op_low) lo_q <= nib;
  end

  always_comb begin
    op1 = alu_op1_sel_bus ? db : op1_q;
    op2 = alu_op2_sel_bus ? db : op2_q;
    b2  = alu_sel_op2_neg ? ~op2 : op2;
    na  = alu_sel_op2_high ? op1[7:4] : op1[3:0];
    nb  = alu_sel_op2_high ? b2[7:4]  : b2[3:0];
    s5  = {1'b0, na} + {1'b0, nb} + {4'b0, alu_core_cf_in};
    co  = 1'b0;
    case ({alu_core_R, alu_core_S, alu_core_V})
      3'b100:  nib = na & nb;
      3'b010:  nib = na ^ nb;
      3'b001:  nib = na | nb;
      default: {co, nib} = s5;
    endcase
    alu_core_cf_out = co;
    alu_zero        = (nib == 4'h0);
    alu_sf_out      = nib[3];
    alu_parity_out  = alu_op_low ? ^nib : ~(alu_parity_in ^ (^nib));
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: whole-byte arithmetic from the op rules.
  task automatic model(input int o, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] r, output logic c, output logic h);
    int ci, t;
    ci = ((o == 1) || (o == 3)) ? int'(model_cf) : 0;
    c = 1'b0; h = 1'b0; r = 8'h00;
    case (o)
      0, 1: begin
        t = int'(a) + int'(b) + ci; r = t[7:0]; c = (t > 255);
        h = (int'(a[3:0]) + int'(b[3:0]) + ci) > 15;
      end
      2, 3, 7: begin
        t = int'(a) - int'(b) - ci; r = t[7:0]; c = (t < 0);
        h = (int'(a[3:0]) - int'(b[3:0]) - ci) < 0;
      end
      4: begin r = a & b; h = 1'b1; end
      5: r = a ^ b;
      default: r = a | b;
    endcase
  endtask

  task automatic chk_flags(input string tag, input logic [7:0] r, input logic c, input logic h);
    chk({tag, "_flags"}, {cf, hf, pf, zf, sf}, {c, h, ~^r, r == 8'h00, r[7]});
  endtask

  task automatic run_op(input int o, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r; logic c, h, sub;
    model(o, a, b, r, c, h);
    sub = (o == 2) || (o == 3) || (o == 7);
    @(negedge clk); start = 1'b1; op = o[2:0]; opa = a; opb = b;
    @(negedge clk); start = 1'b0;
    chk("c1_ctl", {busy, done, opa_req, alu_op1_sel_bus, alu_shift_oe}, 5'b10111);
    @(negedge clk);
    chk("c2_ctl", {busy, done, opb_req, alu_op2_sel_bus, alu_op_low, alu_sel_op2_high}, 6'b101110);
    chk("c2_neg", alu_sel_op2_neg, sub);
    @(negedge clk);
    chk("c3_ctl", {busy, done, alu_res_oe, alu_sel_op2_high, alu_shift_oe}, 5'b11110);
    chk("c3_neg", alu_sel_op2_neg, sub);
    chk("c3_oe", alu_oe, o != 7);
    chk("c3_res", {nib, lo_q}, r);
    @(negedge clk);
    chk("c4_busy", {busy, done}, 2'b00);
    chk_flags("c4", r, c, h);
    model_cf = c;
  endtask

  initial begin
    logic [7:0] r; logic c, h;
    repeat (2) @(negedge clk);
    chk("reset_outs", all_outs, 25'd0);
    nreset = 1'b1;

    run_op(0, 8'h8C, 8'h6D);
    run_op(2, 8'h10, 8'h01);
    run_op(0, 8'hFF, 8'h01);
    run_op(1, 8'hFF, 8'h00);
    run_op(7, 8'h05, 8'h05);
    run_op(4, 8'hF0, 8'h3C);
    run_op(3, 8'h00, 8'h00);

    // start held high: one accept every four cycles
    @(negedge clk); start = 1'b1; op = 3'd0; opa = 8'hA5; opb = 8'h7B;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 12) start = 1'b0;
      chk("hold_done", done, (n % 4) == 3);
      chk("hold_busy", busy, (n % 4) != 0);
    end
    model(0, 8'hA5, 8'h7B, r, c, h);
    chk_flags("hold", r, c, h);
    model_cf = c;

    // async reset in the middle of the low-nibble cycle
    @(negedge clk); start = 1'b1; op = 3'd2; opa = 8'h33; opb = 8'h44;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("mid_low", alu_op_low, 1'b1);
    #2 nreset = 1'b0;
    #1 chk("mid_rst_outs", all_outs, 25'd0);
    @(negedge clk);
    chk("mid_rst_hold", all_outs, 25'd0);
    nreset = 1'b1;
    model_cf = 1'b0;
    run_op(0, 8'h8C, 8'h6D);

    for (int i = 0; i < 24; i++)
      run_op(int'($urandom_range(7, 0)), 8'($urandom), 8'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
